// File: rtl/fir_stream_out_buffer.sv
// Elastic AXI-Stream buffer behind the FIR output port. It keeps a per-frame
// output sample count, a frame-done pulse, and a sticky frame-length error.
module fir_stream_out_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 10
) (
  input  logic                       axis_clk,
  input  logic                       axis_rst_n,
  input  logic                       s_tvalid,
  input  logic [DATA_W-1:0]          s_tdata,
  input  logic                       s_tlast,
  output logic                       s_tready,
  output logic                       m_tvalid,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tlast,
  input  logic                       m_tready,
  input  logic [CNT_W-1:0]           frame_len,
  input  logic                       err_clr,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           out_cnt,
  output logic                       frame_done,
  output logic                       len_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DATA_W:0]   mem [DEPTH];
  logic [DATA_W:0]   head;
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     level_reg, level_next;
  logic [CNT_W-1:0]  in_cnt_reg, in_cnt_next, in_k;
  logic [CNT_W-1:0]  out_cnt_reg, out_cnt_next;
  logic              ready_en_reg;
  logic              frame_done_reg, frame_done_next;
  logic              len_err_reg, len_err_next;
  logic              push, pop, len_bad;

  // ready_en_reg holds s_tready low while reset is asserted.
  assign s_tready = ready_en_reg && (level_reg < LW'(DEPTH));
  assign m_tvalid = (level_reg != '0);
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;
  assign head     = mem[rd_ptr_reg];
  assign m_tdata  = m_tvalid ? head[DATA_W-1:0] : '0;
  assign m_tlast  = m_tvalid ? head[DATA_W] : 1'b0;

  assign level      = level_reg;
  assign out_cnt    = out_cnt_reg;
  assign frame_done = frame_done_reg;
  assign len_err    = len_err_reg;

  always_ff @(posedge axis_clk) begin
    if (push) mem[wr_ptr_reg] <= {s_tlast, s_tdata};
  end

  always_comb begin
    in_k            = in_cnt_reg + CNT_W'(1);
    len_bad         = 1'b0;
    in_cnt_next     = in_cnt_reg;
    out_cnt_next    = out_cnt_reg;
    frame_done_next = 1'b0;
    level_next      = level_reg;

    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase

    // A missing tlast at the programmed length resyncs the input counter.
    if (push) begin
      if (s_tlast) begin
        in_cnt_next = '0;
        len_bad     = (frame_len != '0) && (in_k != frame_len);
      end else if ((frame_len != '0) && (in_k == frame_len)) begin
        in_cnt_next = '0;
        len_bad     = 1'b1;
      end else begin
        in_cnt_next = in_k;
      end
    end

    if (pop) begin
      out_cnt_next    = head[DATA_W] ? '0 : out_cnt_reg + CNT_W'(1);
      frame_done_next = head[DATA_W];
    end

    if (len_bad)      len_err_next = 1'b1;
    else if (err_clr) len_err_next = 1'b0;
    else              len_err_next = len_err_reg;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      in_cnt_reg     <= '0;
      out_cnt_reg    <= '0;
      ready_en_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      len_err_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      level_reg      <= level_next;
      in_cnt_reg     <= in_cnt_next;
      out_cnt_reg    <= out_cnt_next;
      ready_en_reg   <= 1'b1;
      frame_done_reg <= frame_done_next;
      len_err_reg    <= len_err_next;
    end
  end

endmodule

// File: doc/fir_stream_out_buffer.md
Name: fir_stream_out_buffer

Overview:
- AXI-Stream elastic buffer directly downstream of the FIR engine's sm_* output port. It decouples FIR output timing from the consumer (testbench or DMA).
- Stores up to DEPTH samples with their tlast flags and keeps a per-frame output sample count.
- Checks the input frame length against the programmed data length.
- Pulses frame_done when the last sample of a frame leaves the buffer.

Parameters:
- DATA_W, 32, width of the sample data.
- DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 10, width of the frame length and sample counters.

Ports:
- axis_clk  in  1  clock
- axis_rst_n  in  1  asynchronous active-low reset
- s_tvalid  in  1  input sample valid (from FIR sm_tvalid)
- s_tdata  in  DATA_W  input sample (from FIR sm_tdata)
- s_tlast  in  1  input end of frame
- s_tready  out  1  buffer can accept a sample
- m_tvalid  out  1  output sample valid
- m_tdata  out  DATA_W  output sample
- m_tlast  out  1  output end of frame
- m_tready  in  1  consumer ready
- frame_len  in  CNT_W  expected samples per frame (from data-length register); sampled continuously
- err_clr  in  1  synchronous clear of len_err
- level  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- out_cnt  out  CNT_W  output samples handshaked in the current frame
- frame_done  out  1  one-cycle pulse per frame
- len_err  out  1  sticky frame-length error

Behaviour:
- Reset values:
  - s_tready=0 during reset, then 1 from the first cycle after deassertion.
  - m_tvalid=0, m_tdata=0, m_tlast=0.
  - level=0, out_cnt=0, frame_done=0, len_err=0.
  - Read/write pointers and the internal input counter in_cnt reset to 0.
- Storage: circular RAM of DEPTH entries, each {tlast, tdata}. Pointers are clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Push: occurs when s_tvalid && s_tready. s_tready = (level < DEPTH) and is a combinational function of registered level only.
- Pop: occurs when m_tvalid && m_tready. m_tvalid = (level != 0). m_tdata and m_tlast show the head entry.
- Latency: a push into an empty buffer at edge N gives m_tvalid=1 in the cycle after edge N. There is no combinational s->m path.
- level update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, both pointers advance.
- Full (level==DEPTH): s_tready=0. A pop in that cycle does not enable a same-cycle push; s_tready rises in the next cycle.
- Empty (level==0): m_tvalid=0 and m_tready is ignored.
- Output values are stable while m_tvalid=1 and m_tready=0. This is the AXI-Stream hold rule.
- out_cnt:
  - +1 on each pop.
  - On a pop with m_tlast=1: out_cnt goes to 0 and frame_done=1 for exactly one cycle (registered, asserted in the cycle after that edge).
- in_cnt (internal): +1 on each push; goes to 0 on a push with s_tlast=1.
- Length check, evaluated on each push, where k = in_cnt+1:
  - s_tlast=1 and k != frame_len: set len_err.
  - s_tlast=0 and k == frame_len: set len_err, and in_cnt goes to 0 (resync to the next frame).
  - frame_len=0: no check is performed.
- len_err:
  - Stays set until err_clr=1. Clear takes effect at the next edge.
  - If err_clr and a new error occur in the same cycle, the set wins.
  - Errors never block data flow.
- Reset mid-operation: all contents are discarded immediately and asynchronously, and all outputs return to their reset values. No partial frame survives reset.
- frame_len changes while a frame is in flight take effect on the next push comparison. No latching is performed.
- Widths: counters wrap modulo 2^CNT_W. level must never exceed DEPTH; exceeding it is an assertion failure in the bench.

Test Plan:
- Frame pass-through:
  - Stimulus: frame_len=5; push 1,2,3,4,5 with tlast on 5; m_tready=1.
  - Required: m_tdata 1..5 in order; first m_tvalid one cycle after the first push; frame_done pulses once; out_cnt returns to 0; len_err=0.
- Full back-pressure:
  - Stimulus: DEPTH=8, m_tready=0, push 10 samples.
  - Required: 8 accepted; level=8; s_tready=0.
  - Then m_tready=1 for one cycle. Required: level=7, s_tready=1 in the next cycle, 9th sample accepted after that.
- Simultaneous push/pop:
  - Stimulus: level=3; push and pop every cycle for 20 cycles.
  - Required: level stays 3; output order equals input order; correct across pointer wrap.
- Length errors:
  - Stimulus: frame_len=4; tlast on the 3rd sample.
  - Required: len_err=1 after that edge; data still delivered.
  - Stimulus: err_clr pulse. Required: len_err=0.
  - Stimulus: send 4 samples with no tlast. Required: len_err=1 again.
- Output hold:
  - Stimulus: m_tready toggles 0/1 randomly during a 6-sample frame.
  - Required: m_tdata and m_tlast never change while m_tvalid && !m_tready; exactly 6 pops; one frame_done.
- Reset mid-frame:
  - Stimulus: level=5; assert axis_rst_n=0 mid-cycle.
  - Required: m_tvalid, level, out_cnt go to 0 immediately.
  - Stimulus: after release, push a new frame. Required: the new frame starts cleanly with only new data observed.
